filter_window_5x5: RTL and testbench

//  Upstream stage of the 5x5 convolution. Turns a raster pixel stream (one pixel/clk max) into a
//  5x5 window plus a valid strobe, using 4 line buffers and a 5x5 register array.
//  o_valid drives the conv stage's i_en; o_win slices drive its i_x00..i_x44 taps.

---
 rtl/filter_pkg.sv | 20 ++
 rtl/filter_line_buffer.sv | 41 ++++
 rtl/filter_window_5x5.sv | 201 ++++++++++++++++++++
 tb/tb_filter_window_5x5.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// ----------------------------------------------------------------------------------------------
// filter_pkg
//  Shared constants for the 5x5 filter pipeline (window generator and convolution stage).
//  Both stages use the same tap ordering: tap index = 5*row + col, row 0 / col 0 being the
//  oldest (top-left) pixel of the window.
//  Contents:
//    WIN_K     window edge length (5)
//    WIN_TAPS  number of taps in one window (25)
//    tap_idx   maps a (row, col) window position to its tap index
// ----------------------------------------------------------------------------------------------
package filter_pkg;

    localparam int unsigned WIN_K    = 5;
    localparam int unsigned WIN_TAPS = WIN_K * WIN_K;

    function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
        return WIN_K * r + c;
    endfunction

endpackage

// File: rtl/filter_line_buffer.sv
// ----------------------------------------------------------------------------------------------
// filter_line_buffer
//  One line of pixel delay, built as a simple dual-port RAM with a registered read port so it
//  maps onto block RAM. The caller supplies separate read and write addresses; the top level
//  prefetches the column it expects to consume next, so read and write never hit the same
//  address in the same cycle.
//  Ports:
//    clk      in   clock
//    i_we     in   write enable (one write per accepted pixel)
//    i_waddr  in   write column
//    i_wdata  in   pixel to store
//    i_raddr  in   read column, registered into o_rdata every cycle
//    o_rdata  out  pixel read from i_raddr on the previous clock
//  Storage is intentionally not reset.
// ----------------------------------------------------------------------------------------------
module filter_line_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 640,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/filter_window_5x5.sv
// ----------------------------------------------------------------------------------------------
// filter_window_5x5
//  Turns a raster pixel stream (at most one pixel per clock) into a 5x5 window plus a one-cycle
//  valid strobe for the convolution stage. Four chained line buffers supply the four previous
//  lines of the current column; a 5x4 shift array keeps the previous four columns. Only full
//  windows are emitted, so the output frame is (IMG_WIDTH-4) x (IMG_HEIGHT-4).
//  Ports:
//    clk      in   clock
//    rst      in   synchronous active-high reset
//    i_valid  in   pixel qualifier; no backpressure
//    i_sof    in   first pixel of frame, sampled only with i_valid
//    i_data   in   pixel, raster order
//    o_valid  out  window valid, one pulse per window
//    o_win    out  window, o_win[(5*r+c)*DATA_WIDTH +: DATA_WIDTH] = x_rc, x44 newest pixel
//    o_row    out  window-centre row    (only with FILTER_WIN_COORD_EN)
//    o_col    out  window-centre column (only with FILTER_WIN_COORD_EN)
//  Build option: define FILTER_WIN_COORD_EN to add the o_row/o_col outputs.
// ----------------------------------------------------------------------------------------------
module filter_window_5x5
    import filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic                             i_sof,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_valid,
    output logic [WIN_TAPS*DATA_WIDTH-1:0]   o_win
`ifdef FILTER_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_HEIGHT)-1:0]    o_row,
    output logic [$clog2(IMG_WIDTH)-1:0]     o_col
`endif
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam int unsigned NUM_LINES = WIN_K - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN_K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_K - 1);
    localparam logic [CW-1:0] COL_HALF  = CW'(WIN_K / 2);
    localparam logic [RW-1:0] ROW_HALF  = RW'(WIN_K / 2);

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic [CW-1:0] w_cur_col;
    logic [RW-1:0] w_cur_row;
    logic [CW-1:0] w_col_next;
    logic [RW-1:0] w_row_next;
    logic          w_accept;
    logic          w_fire;

    assign w_accept = i_valid && !rst;

    // i_sof relocates the current pixel to (0,0) regardless of where the counters were.
    assign w_cur_col = i_sof ? '0 : r_col;
    assign w_cur_row = i_sof ? '0 : r_row;

    always_comb begin
        w_col_next = w_cur_col + 1'b1;
        w_row_next = w_cur_row;
        if (w_cur_col == COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_cur_row == ROW_LAST) ? '0 : w_cur_row + 1'b1;
        end
    end

    // A full window exists only once four earlier lines and four earlier columns of the same
    // frame have been seen; this also keeps stale line-buffer data from a previous frame out.
    assign w_fire = w_accept && (w_cur_row >= ROW_FIRST) && (w_cur_col >= COL_FIRST);

    // ------------------------------------------------------------------
    // Line buffers: w_tap[k] holds pixel (R-1-k, C) for the pixel being accepted
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_tap [NUM_LINES];
    logic [CW-1:0]         w_raddr;

    // Prefetch: after an accept, read the column expected next so its data is ready when that
    // pixel arrives. While idle keep reading the same column so the taps stay stable. A
    // mid-frame i_sof makes the prefetched column wrong for one pixel, but that pixel sits in
    // row 0, whose line-buffer taps never reach a valid window.
    assign w_raddr = rst ? '0 : (i_valid ? w_col_next : r_col);

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        logic [DATA_WIDTH-1:0] w_wdata;

        if (k == 0) begin : g_first
            assign w_wdata = i_data;
        end else begin : g_chain
            assign w_wdata = w_tap[k-1];
        end

        filter_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .ADDR_WIDTH (CW)
        ) u_line (
            .clk     (clk),
            .i_we    (w_accept),
            .i_waddr (w_cur_col),
            .i_wdata (w_wdata),
            .i_raddr (w_raddr),
            .o_rdata (w_tap[k])
        );
    end

    // ------------------------------------------------------------------
    // Column assembly and 5x4 shift array
    // ------------------------------------------------------------------
    // w_col_vec[r] is window row r of the incoming column: row 0 oldest line, row 4 = i_data.
    logic [DATA_WIDTH-1:0] w_col_vec [WIN_K];
    logic [DATA_WIDTH-1:0] r_sh      [WIN_K][WIN_K-1];
    logic [WIN_TAPS*DATA_WIDTH-1:0] w_win;

    always_comb begin
        for (int unsigned r = 0; r < NUM_LINES; r++) begin
            w_col_vec[r] = w_tap[NUM_LINES-1-r];
        end
        w_col_vec[WIN_K-1] = i_data;
    end

    // Shift array only moves on accepted pixels; it is fully refilled before any window that
    // uses it can fire, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned r = 0; r < WIN_K; r++) begin
                for (int unsigned c = 0; c < WIN_K - 2; c++) begin
                    r_sh[r][c] <= r_sh[r][c+1];
                end
                r_sh[r][WIN_K-2] <= w_col_vec[r];
            end
        end
    end

    always_comb begin
        w_win = '0;
        for (int unsigned r = 0; r < WIN_K; r++) begin
            for (int unsigned c = 0; c < WIN_K - 1; c++) begin
                w_win[tap_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = r_sh[r][c];
            end
            w_win[tap_idx(r, WIN_K-1)*DATA_WIDTH +: DATA_WIDTH] = w_col_vec[r];
        end
    end

    // ------------------------------------------------------------------
    // Counters and output registers
    // ------------------------------------------------------------------
    logic                           r_valid;
    logic [WIN_TAPS*DATA_WIDTH-1:0] r_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_win   <= '0;
        end else begin
            r_valid <= w_fire;
            if (i_valid) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
            end
            if (w_fire) begin
                r_win <= w_win;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_win   = r_win;

`ifdef FILTER_WIN_COORD_EN
    logic [RW-1:0] r_crow;
    logic [CW-1:0] r_ccol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crow <= '0;
            r_ccol <= '0;
        end else if (w_fire) begin
            r_crow <= w_cur_row - ROW_HALF;
            r_ccol <= w_cur_col - COL_HALF;
        end
    end

    assign o_row = r_crow;
    assign o_col = r_ccol;
`endif

endmodule

// File: tb/tb_filter_window_5x5.sv
module tb_filter_window_5x5;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            i_sof = 1'b0;
    logic [DW-1:0]   i_data = '0;
    logic            o_valid;
    logic [25*DW-1:0] o_win;
`ifdef FILTER_WIN_COORD_EN
    logic [$clog2(H)-1:0] o_row;
    logic [$clog2(W)-1:0] o_col;
`endif

    always #5 clk = ~clk;

    filter_window_5x5 #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_win   (o_win)
`ifdef FILTER_WIN_COORD_EN
        ,
        .o_row   (o_row),
        .o_col   (o_col)
`endif
    );

    typedef struct {
        logic [25*DW-1:0] win;
        int               row;
        int               col;
    } exp_t;

    exp_t             q[$];
    exp_t             e;
    logic [25*DW-1:0] exp_hold = '0;
    int               n_vec = 0;
    int               n_err = 0;
    bit               mon_en = 1'b0;
    int               drain_req = 0;
    int               drain_seen = 0;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) begin
                n_vec++;
                assert (q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_valid observed o_valid=1 o_win=%h required o_valid=0",
                           o_win);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    assert (o_win === e.win) else begin
                        n_err++;
                        $error("FAIL window observed=%h required=%h", o_win, e.win);
                    end
`ifdef FILTER_WIN_COORD_EN
                    n_vec++;
                    assert ((int'(o_row) == e.row) && (int'(o_col) == e.col)) else begin
                        n_err++;
                        $error("FAIL coord observed=(%0d,%0d) required=(%0d,%0d)",
                               o_row, o_col, e.row, e.col);
                    end
`endif
                    exp_hold = e.win;
                end
            end else begin
                n_vec++;
                assert (o_win === exp_hold) else begin
                    n_err++;
                    $error("FAIL hold observed=%h required=%h", o_win, exp_hold);
                end
            end
            if (drain_req != drain_seen) begin
                drain_seen = drain_req;
                n_vec++;
                assert (q.size() == 0) else begin
                    n_err++;
                    $error("FAIL missing_windows observed %0d outstanding required 0", q.size());
                end
            end
            // Reset takes effect at the coming edge; from then on o_win must read zero.
            if (rst) begin
                exp_hold = '0;
                q.delete();
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the consuming edge.
    task automatic cyc(input logic v, input logic s, input logic [DW-1:0] d);
        i_valid = v;
        i_sof   = s;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    // Drive pixel (r,c) of a frame with value base+{r,c}, with optional random idle gaps.
    task automatic pix(input logic s, input int r, input int c, input int base, input int gap);
        exp_t x;
        while (gap > 0 && $urandom_range(99) < gap) cyc(1'b0, 1'b0, '0);
        if (r >= 4 && c >= 4) begin
            x.win = '0;
            for (int rr = 0; rr < 5; rr++) begin
                for (int cc = 0; cc < 5; cc++) begin
                    x.win[(5*rr+cc)*DW +: DW] = DW'(base + (r-4+rr)*16 + (c-4+cc));
                end
            end
            x.row = r - 2;
            x.col = c - 2;
            q.push_back(x);
        end
        cyc(1'b1, s, DW'(base + r*16 + c));
    endtask

    task automatic frame(input int base, input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pix((r == 0 && c == 0), r, c, base, gap);
            end
        end
    endtask

    task automatic drain();
        repeat (3) cyc(1'b0, 1'b0, '0);
        drain_req++;
        repeat (2) cyc(1'b0, 1'b0, '0);
    endtask

    initial begin
        // Power-on reset; line buffers hold X until written.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, '0);

        // 1: continuous frame
        frame(0, 0);
        drain();

        // 2: same frame with ~40% idle cycles
        frame(0, 40);
        drain();

        // 3: partial frame abandoned by i_sof where pixel 0x23 would be
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 2 || c < 3) pix((r == 0 && c == 0), r, c, 0, 0);
            end
        end
        frame(0, 0);
        drain();

        // 4: reset in row 4; the pixel offered with rst would otherwise complete a window
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 4 || c < 4) pix((r == 0 && c == 0), r, c, 0, 0);
            end
        end
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'h44);
        rst = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, '0);
        frame(0, 0);
        drain();

        // 5: two frames back to back, second offset by 0x80
        frame(0, 0);
        frame(8'h80, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
